// File: rtl/wb_sys_ctrl_if.sv
// Wishbone classic bus bundle between the UART bus master and wb_sys_ctrl.
//   wb_data_i   : write data (master -> slave)
//   wb_addr_i   : byte address (master -> slave)
//   wb_cyc_i    : bus cycle (master -> slave)
//   wb_strobe_i : strobe (master -> slave)
//   wb_we_i     : write enable (master -> slave)
//   wb_data_o   : read data, valid while wb_ack_o=1 (slave -> master)
//   wb_ack_o    : single-cycle acknowledge (slave -> master)
interface wb_sys_ctrl_if;
   logic [31:0] wb_data_i;
   logic [31:0] wb_addr_i;
   logic        wb_cyc_i;
   logic        wb_strobe_i;
   logic        wb_we_i;
   logic [31:0] wb_data_o;
   logic        wb_ack_o;

   modport slave (
      input  wb_data_i, wb_addr_i, wb_cyc_i, wb_strobe_i, wb_we_i,
      output wb_data_o, wb_ack_o
   );

   modport master (
      output wb_data_i, wb_addr_i, wb_cyc_i, wb_strobe_i, wb_we_i,
      input  wb_data_o, wb_ack_o
   );
endinterface

// File: rtl/wb_sys_ctrl.sv
// System controller: stretches the board reset into a power-on reset for the
// system core and exposes halt, soft reset, N-cycle single-step and a run-cycle
// counter as Wishbone registers in a 16-byte window at BASE_ADDR.
//   clock     : system clock
//   reset     : synchronous active-high board reset
//   wb        : Wishbone classic slave (wb_sys_ctrl_if.slave)
//   sys_reset : active-high reset to system core
//   sys_halt  : active-high halt to system core
// Register map (wb_addr_i[3:2]): 0 CTRL {SRST,HALT}, 1 STEP remaining,
// 2 STATUS {state[6:4], step_busy, sys_halt, sys_reset}, 3 CYCLES.
module wb_sys_ctrl #(
   parameter int unsigned POR_CYCLES    = 15,
   parameter int unsigned SRST_CYCLES   = 4,
   parameter bit          HALT_ON_RESET = 1'b0,
   parameter int unsigned STEP_WIDTH    = 16,
   parameter logic [31:0] BASE_ADDR     = 32'h0000_1000
) (
   input  logic         clock,
   input  logic         reset,
   wb_sys_ctrl_if.slave wb,
   output logic         sys_reset,
   output logic         sys_halt
);

   typedef enum logic [2:0] {
      ST_POR    = 3'd0,
      ST_RUN    = 3'd1,
      ST_HALTED = 3'd2,
      ST_STEP   = 3'd3,
      ST_SRST   = 3'd4
   } state_t;

   localparam logic [15:0] POR_LAST  = 16'(POR_CYCLES - 1);
   localparam logic [15:0] SRST_LAST = 16'(SRST_CYCLES - 1);
   localparam state_t      EXIT_ST   = HALT_ON_RESET ? ST_HALTED : ST_RUN;

   state_t                state, state_nxt;
   logic [15:0]           cnt, cnt_nxt;
   logic [STEP_WIDTH-1:0] remaining, remaining_nxt;
   logic                  halt, halt_nxt;
   logic [31:0]           cycles;
   logic [31:0]           rd_data;

   logic                  req, hit, wr, wr_ctrl, wr_step, wr_cycles, srst_req;
   logic [STEP_WIDTH-1:0] step_n;
   logic                  step_busy;
   logic                  unused_bits;

   // A request is only taken while ack is low, so acks can never be back-to-back.
   assign req       = wb.wb_cyc_i & wb.wb_strobe_i & ~wb.wb_ack_o;
   assign hit       = wb.wb_addr_i[31:4] == BASE_ADDR[31:4];
   assign wr        = req & hit & wb.wb_we_i;
   assign wr_ctrl   = wr & (wb.wb_addr_i[3:2] == 2'd0);
   assign wr_step   = wr & (wb.wb_addr_i[3:2] == 2'd1);
   assign wr_cycles = wr & (wb.wb_addr_i[3:2] == 2'd3);
   assign srst_req  = wr_ctrl & wb.wb_data_i[1];
   assign step_n    = wb.wb_data_i[STEP_WIDTH-1:0];
   assign unused_bits = ^{wb.wb_data_i, wb.wb_addr_i[1:0]};

   assign sys_reset = (state == ST_POR) || (state == ST_SRST);
   assign sys_halt  = sys_reset ? HALT_ON_RESET : (state == ST_HALTED);
   assign step_busy = state == ST_STEP;

   always_comb begin
      rd_data = '0;
      if (hit) begin
         case (wb.wb_addr_i[3:2])
            2'd0:    rd_data[0] = halt;
            2'd1:    rd_data[STEP_WIDTH-1:0] = remaining;
            2'd2:    rd_data[6:0] = {state, 1'b0, step_busy, sys_halt, sys_reset};
            default: rd_data = cycles;
         endcase
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      remaining_nxt = remaining;
      halt_nxt      = halt;
      case (state)
         ST_POR, ST_SRST: begin
            // HALT writes land here but are overridden on exit.
            if (wr_ctrl && !wb.wb_data_i[1]) halt_nxt = wb.wb_data_i[0];
            if (state == ST_SRST && srst_req) begin
               cnt_nxt = '0;
            end else if (cnt == ((state == ST_POR) ? POR_LAST : SRST_LAST)) begin
               cnt_nxt   = '0;
               state_nxt = EXIT_ST;
               halt_nxt  = HALT_ON_RESET;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         default: begin
            if (state == ST_STEP) begin
               if (remaining == STEP_WIDTH'(1)) begin
                  remaining_nxt = '0;
                  state_nxt     = ST_HALTED;
                  halt_nxt      = 1'b1;
               end else begin
                  remaining_nxt = remaining - STEP_WIDTH'(1);
               end
            end
            if (wr_step && step_n != '0) begin
               remaining_nxt = step_n;
               state_nxt     = ST_STEP;
            end
            if (srst_req) begin
               // Soft reset wins over a HALT value in the same write.
               state_nxt     = ST_SRST;
               cnt_nxt       = '0;
               remaining_nxt = '0;
            end else if (wr_ctrl) begin
               halt_nxt      = wb.wb_data_i[0];
               state_nxt     = wb.wb_data_i[0] ? ST_HALTED : ST_RUN;
               remaining_nxt = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_POR;
         cnt          <= '0;
         remaining    <= '0;
         halt         <= 1'b0;
         cycles       <= '0;
         wb.wb_ack_o  <= 1'b0;
         wb.wb_data_o <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         remaining    <= remaining_nxt;
         halt         <= halt_nxt;
         wb.wb_ack_o  <= req;
         wb.wb_data_o <= req ? rd_data : '0;
         if (wr_cycles)
            cycles <= '0;
         else if (state == ST_RUN || state == ST_STEP)
            cycles <= cycles + 32'd1;
      end
   end

endmodule
